// File: rtl/cm3_excl_mon_mp_if.sv
// rtl/cm3_excl_mon_mp_if.sv - address-phase bus bundle between the bus matrix and the exclusive monitor
interface cm3_excl_mon_mp_if #(
    parameter int AW      = 32,
    parameter int MASTERS = 4
);
    localparam int ID_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    logic               halted;
    logic               valid;
    logic [AW-1:0]      haddr;
    logic               hwrite;
    logic               exreq;
    logic [ID_W-1:0]    mid;
    logic               clrex;
    logic [ID_W-1:0]    clrex_id;
    logic               exresp;
    logic               hwriteout;
    logic [MASTERS-1:0] mon_valid;

    // Fabric side: drives the address phase, observes the monitor verdict
    modport master (
        output halted, valid, haddr, hwrite, exreq, mid, clrex, clrex_id,
        input  exresp, hwriteout, mon_valid
    );

    // Monitor side
    modport slave (
        input  halted, valid, haddr, hwrite, exreq, mid, clrex, clrex_id,
        output exresp, hwriteout, mon_valid
    );
endinterface

// File: rtl/cm3_excl_mon_mp.sv
// rtl/cm3_excl_mon_mp.sv - multi-master LDREX/STREX exclusive-access monitor with per-master reservations
module cm3_excl_mon_mp #(
    parameter int AW        = 32,
    parameter int MASTERS   = 4,
    parameter int GRAN_LOG2 = 2,
    parameter int TIMEOUT   = 128
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    cm3_excl_mon_mp_if.slave        bus
);
    localparam int ID_W  = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int TAG_W = AW - GRAN_LOG2;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic TO_EN = (TIMEOUT != 0);

    logic [MASTERS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [MASTERS];
    logic [TAG_W-1:0]   tag_d [MASTERS];
    logic [CNT_W-1:0]   cnt_q [MASTERS];
    logic [CNT_W-1:0]   cnt_d [MASTERS];
    logic               exresp_q, exresp_d;

    logic [TAG_W-1:0]   addr_tag;
    logic [MASTERS-1:0] match;
    logic [MASTERS-1:0] own;
    logic [MASTERS-1:0] clr_own;
    logic               mid_ok;
    logic               ex_rd;
    logic               ex_wr;
    logic               nrm_wr;
    logic               pass;
    logic               hwriteout;

    // Low address bits below the granule never take part in the tag compare
    logic unused_addr;
    assign unused_addr = ^bus.haddr;

    // Decode the address phase, the per-entry match, and the next reservation state
    always_comb begin
        addr_tag = bus.haddr[AW-1:GRAN_LOG2];
        match    = '0;
        own      = '0;
        clr_own  = '0;
        for (int i = 0; i < MASTERS; i++) begin
            match[i]   = valid_q[i] && (tag_q[i] == addr_tag);
            own[i]     = (bus.mid == ID_W'(i));
            clr_own[i] = (bus.clrex_id == ID_W'(i));
        end
        // An ID beyond the table has no entry, so its traffic is treated as ordinary
        mid_ok = |own;
        ex_rd  = bus.valid && bus.exreq && !bus.hwrite && mid_ok;
        ex_wr  = bus.valid && bus.exreq &&  bus.hwrite && mid_ok;
        nrm_wr = bus.valid && bus.hwrite && !(bus.exreq && mid_ok);
        pass   = ex_wr && |(match & own);

        hwriteout = bus.hwrite && !(ex_wr && !pass);
        exresp_d  = !(ex_rd || pass);

        valid_d = valid_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < MASTERS; i++) begin
            logic expired;
            logic clear;
            // Expiry still leaves the entry valid for this cycle's compare; it drops at the edge
            expired = TO_EN && valid_q[i] && !bus.halted && (cnt_q[i] == '0);
            clear   = (ex_wr && own[i])
                    || (pass && match[i])
                    || (nrm_wr && match[i])
                    || (bus.clrex && clr_own[i])
                    || expired;
            if (TO_EN && valid_q[i] && !bus.halted && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            if (ex_rd && own[i]) begin
                valid_d[i] = 1'b1;
                tag_d[i]   = addr_tag;
                cnt_d[i]   = CNT_INIT;
            end else if (clear) begin
                valid_d[i] = 1'b0;
                cnt_d[i]   = '0;
            end
        end
    end

    // Reservation table and data-phase response register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q  <= '0;
            exresp_q <= 1'b1;
            for (int i = 0; i < MASTERS; i++) begin
                tag_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            exresp_q <= exresp_d;
            for (int i = 0; i < MASTERS; i++) begin
                tag_q[i] <= tag_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.hwriteout = hwriteout;
    assign bus.exresp    = exresp_q;
    assign bus.mon_valid = valid_q;
endmodule
